collision_rect_writer: RTL and testbench
========================================

Name: collision_rect_writer

Overview:
- Writer side of the collision-map RAM that the collision probe reads (19-bit address = x + y*640, 3-bit collision code per pixel).
- Paints an axis-aligned rectangle of a given code (moving platform, door, elevator) into the map, one pixel write per clock, in raster order.
- Sits between game-object logic (request/ack handshake) and the map RAM write port.

Parameters:
- H_RES, 640, map width in pixels; row stride of the address.
- V_RES, 480, map height in pixels.
- ADDR_W, 19, RAM address width.
- CODE_W, 3, collision code width.

Ports:
- vga_clk  input  1  sole clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  1  start request; sampled only in IDLE.
- rect_left  input  10  inclusive left x.
- rect_right  input  10  inclusive right x.
- rect_top  input  10  inclusive top y.
- rect_bottom  input  10  inclusive bottom y.
- rect_code  input  CODE_W  code to paint.
- ack  output  1  one-cycle pulse: request accepted.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse after the last write.
- wr_en  output  1  RAM write strobe.
- wr_addr  output  ADDR_W  RAM write address.
- wr_data  output  CODE_W  RAM write data.

Behaviour:
- Reset (async, reset_n=0): state IDLE; ack, busy, done, wr_en = 0; wr_addr, wr_data = 0; latched rectangle cleared. Reset mid-fill aborts immediately; no further writes and no done pulse.
- States: IDLE -> FILL -> DONE -> IDLE.
- IDLE: on req=1, latch clamped coordinates and code, pulse ack in the same cycle, and go to FILL. req is ignored in every other state, with no queueing.
- Clamping at acceptance: right = min(rect_right, H_RES-1); bottom = min(rect_bottom, V_RES-1). left and top are used unchanged.
- Empty rectangle: if left > clamped right, or top > clamped bottom, go directly to DONE with zero writes.
- FILL: one write per cycle, with wr_en=1 and wr_data=latched code.
  - Start at (left, top) and increment x to right.
  - At x==right: wrap x to left and increment y.
  - Leave FILL after writing (right, bottom).
  - Address is built incrementally: row_base += H_RES per row; wr_addr = row_base + x. No multiplier in the per-pixel path. The one multiply top*H_RES at acceptance is allowed, registered.
- Timing: acceptance at cycle 0; writes occupy cycles 1 .. W*H, where W = right-left+1 and H = bottom-top+1. busy is high on the same cycles. DONE follows the last write: done=1 and busy=1 for one cycle, then IDLE. The next req is accepted the cycle after that.
- wr_en=0 outside FILL. wr_addr and wr_data hold their last values when idle.
- Inputs change freely after ack; only latched values are used.
- Full-screen rectangle: 307200 writes; last wr_addr = 307199. The internal row_base must not overflow ADDR_W.

Optional Feature:
- Macro COLL_ERASE_PREV_EN.
- Defined:
  - The block keeps the last painted rectangle; this register resets to empty.
  - On acceptance it first enters state ERASE, writing code 0 over the previous rectangle in the same raster order. It then enters FILL for the new rectangle.
  - busy spans both passes. Latency = prev W*H + new W*H writes, then DONE.
  - An empty previous rectangle skips ERASE.
  - An empty new rectangle still performs ERASE, then updates the stored rectangle to empty.
- Undefined: no ERASE state and no stored rectangle; only FILL as above.

Test Plan:
- Basic paint: req with (10,20)-(12,21), code 5 -> ack in cycle 0; wr_addr 12810, 12811, 12812, 13450, 13451, 13452 on cycles 1-6 with wr_data=5; done=1 on cycle 7; busy=0 on cycle 8.
- Clip: req (638,479)-(700,600), code 2 -> clamped to (638,479)-(639,479); exactly 2 writes at addresses 307198, 307199; then done.
- Empty: req with left=50, right=40 -> ack; no wr_en; done on cycle 1.
- Busy ignore and reset: req held high through a 3x3 fill -> only one ack, 9 writes. Second run: assert reset_n=0 after write 4 -> all outputs 0 asynchronously, no done; after release, a new req is accepted normally.
- Single pixel: req (0,0)-(0,0), code 7 -> one write, addr 0, data 7; done on cycle 2.
- COLL_ERASE_PREV_EN: paint (10,20)-(12,21), then (11,20)-(11,20), code 3 -> six writes of code 0 at the first rectangle's addresses, then one write of code 3 at 12811, then done; busy high for 8 cycles.

Source files
------------

// File: rtl/collision_rect_writer.sv
// collision_rect_writer: paints a clamped rectangle into the collision map RAM, one pixel per clock in raster order.
// Optional COLL_ERASE_PREV_EN: erase the previously painted rectangle (code 0) before painting each new one.
module collision_rect_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int CODE_W = 3
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [9:0]        rect_left,
  input  logic [9:0]        rect_right,
  input  logic [9:0]        rect_top,
  input  logic [9:0]        rect_bottom,
  input  logic [CODE_W-1:0] rect_code,
  output logic              ack,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CODE_W-1:0] wr_data
);
`ifdef COLL_ERASE_PREV_EN
  typedef enum logic [1:0] {IDLE, FILL, DONE, ERASE} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
`endif
  localparam logic [9:0] X_MAX = 10'(H_RES - 1);
  localparam logic [9:0] Y_MAX = 10'(V_RES - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);
  state_t state;
  logic [9:0] a_left, a_right, a_bottom, x, y, c_right, c_bottom, next_x;
  logic [ADDR_W-1:0] row_base, c_base, next_base;
  logic c_empty, wrap, last;
`ifdef COLL_ERASE_PREV_EN
  logic [9:0] n_left, n_right, n_top, n_bottom, p_left, p_right, p_top, p_bottom;
  logic [ADDR_W-1:0] n_base, p_base;
  logic [CODE_W-1:0] n_code;
  logic n_empty, p_valid;
`endif
  always_comb begin
    c_right   = rect_right > X_MAX ? X_MAX : rect_right;
    c_bottom  = rect_bottom > Y_MAX ? Y_MAX : rect_bottom;
    c_empty   = rect_left > c_right || rect_top > c_bottom;
    c_base    = ADDR_W'(rect_top) * STRIDE;
    wrap      = x == a_right;
    last      = wrap && y == a_bottom;
    next_x    = wrap ? a_left : x + 10'd1;
    next_base = wrap ? row_base + STRIDE : row_base;
  end
  assign ack = reset_n && req && state == IDLE;
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      a_left   <= '0;
      a_right  <= '0;
      a_bottom <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
`ifdef COLL_ERASE_PREV_EN
      n_left   <= '0;
      n_right  <= '0;
      n_top    <= '0;
      n_bottom <= '0;
      n_base   <= '0;
      n_code   <= '0;
      n_empty  <= 1'b0;
      p_left   <= '0;
      p_right  <= '0;
      p_top    <= '0;
      p_bottom <= '0;
      p_base   <= '0;
      p_valid  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req) begin
          busy <= 1'b1;
`ifdef COLL_ERASE_PREV_EN
          n_left   <= rect_left;
          n_right  <= c_right;
          n_top    <= rect_top;
          n_bottom <= c_bottom;
          n_base   <= c_base;
          n_code   <= rect_code;
          n_empty  <= c_empty;
          if (p_valid) begin
            state    <= ERASE;
            a_left   <= p_left;
            a_right  <= p_right;
            a_bottom <= p_bottom;
            x        <= p_left;
            y        <= p_top;
            row_base <= p_base;
            wr_en    <= 1'b1;
            wr_addr  <= p_base + ADDR_W'(p_left);
            wr_data  <= '0;
          end else
`endif
          if (c_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= FILL;
            a_left   <= rect_left;
            a_right  <= c_right;
            a_bottom <= c_bottom;
            x        <= rect_left;
            y        <= rect_top;
            row_base <= c_base;
            wr_en    <= 1'b1;
            wr_addr  <= c_base + ADDR_W'(rect_left);
            wr_data  <= rect_code;
          end
        end
`ifdef COLL_ERASE_PREV_EN
        ERASE: if (!last) begin
          x        <= next_x;
          y        <= wrap ? y + 10'd1 : y;
          row_base <= next_base;
          wr_addr  <= next_base + ADDR_W'(next_x);
        end else if (n_empty) begin
          state <= DONE;
          wr_en <= 1'b0;
          done  <= 1'b1;
        end else begin
          state    <= FILL;
          a_left   <= n_left;
          a_right  <= n_right;
          a_bottom <= n_bottom;
          x        <= n_left;
          y        <= n_top;
          row_base <= n_base;
          wr_addr  <= n_base + ADDR_W'(n_left);
          wr_data  <= n_code;
        end
`endif
        FILL: if (!last) begin
          x        <= next_x;
          y        <= wrap ? y + 10'd1 : y;
          row_base <= next_base;
          wr_addr  <= next_base + ADDR_W'(next_x);
        end else begin
          state <= DONE;
          wr_en <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
`ifdef COLL_ERASE_PREV_EN
          p_left   <= n_left;
          p_right  <= n_right;
          p_top    <= n_top;
          p_bottom <= n_bottom;
          p_base   <= n_base;
          p_valid  <= !n_empty;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_collision_rect_writer.sv
// tb_collision_rect_writer: table, hand-written and random rectangles checked against a pixel-list reference model.
module tb_collision_rect_writer;
  logic vga_clk = 1'b0, reset_n = 1'b0, req = 1'b0;
  logic [9:0] rect_left = '0, rect_right = '0, rect_top = '0, rect_bottom = '0;
  logic [2:0] rect_code = '0;
  logic ack, busy, done, wr_en;
  logic [18:0] wr_addr;
  logic [2:0] wr_data;
  int checks = 0, errors = 0;
  int prev_l = 1, prev_r = 0, prev_t = 1, prev_b = 0;
  int prev_n;
  int exp_addr[$];
  int exp_data[$];

  typedef struct {int l; int r; int t; int b; int code; int n; int first; int last;} vec_t;
  vec_t vecs[6];

  collision_rect_writer dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req),
    .rect_left(rect_left), .rect_right(rect_right), .rect_top(rect_top), .rect_bottom(rect_bottom),
    .rect_code(rect_code), .ack(ack), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int add_rect(input int l, input int r, input int t, input int b, input int code);
    int cnt = 0;
    if (r > 639) r = 639;
    if (b > 479) b = 479;
    for (int yy = t; yy <= b; yy++)
      for (int xx = l; xx <= r; xx++) begin
        exp_addr.push_back(xx + yy * 640);
        exp_data.push_back(code);
        cnt++;
      end
    return cnt;
  endfunction

  task automatic prepare(input int l, input int r, input int t, input int b, input int code);
    int dummy;
    exp_addr.delete();
    exp_data.delete();
    prev_n = 0;
`ifdef COLL_ERASE_PREV_EN
    prev_n = add_rect(prev_l, prev_r, prev_t, prev_b, 0);
    prev_l = l; prev_t = t;
    prev_r = r > 639 ? 639 : r;
    prev_b = b > 479 ? 479 : b;
`endif
    dummy = add_rect(l, r, t, b, code);
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input int l, input int r, input int t, input int b, input int code,
                         input bit hold, input int abort_after,
                         output int n, output int first, output int last_a);
    bit seen_done = 0;
    int acks = 0;
    prepare(l, r, t, b, code);
    n = 0; first = -1; last_a = -1;
    req = 1'b1;
    rect_left = 10'(l); rect_right = 10'(r); rect_top = 10'(t); rect_bottom = 10'(b);
    rect_code = 3'(code);
    #1 check("ack at accept", ack, 1);
    @(posedge vga_clk); #1;
    if (!hold) req = 1'b0;
    rect_left = 10'($urandom); rect_right = 10'($urandom);
    rect_top = 10'($urandom); rect_bottom = 10'($urandom); rect_code = 3'($urandom);
    for (int c = 1; c <= 20000 && !seen_done; c++) begin
      check("busy during op", busy, 1);
      if (ack) acks++;
      if (wr_en) begin
        if (n < exp_addr.size()) begin
          check("wr_addr", wr_addr, exp_addr[n]);
          check("wr_data", wr_data, exp_data[n]);
        end else check("extra write", n, exp_addr.size());
        if (n == prev_n) first = int'(wr_addr);
        last_a = int'(wr_addr);
        n++;
        if (n == abort_after) begin
          #2 reset_n = 1'b0;
          #1;
          check("abort wr_en", wr_en, 0);
          check("abort busy", busy, 0);
          check("abort done", done, 0);
          check("abort ack", ack, 0);
          check("abort wr_addr", wr_addr, 0);
          check("abort wr_data", wr_data, 0);
          repeat (2) @(posedge vga_clk);
          #1;
          check("no done in reset", done, 0);
          check("no write in reset", wr_en, 0);
          reset_n = 1'b1;
          prev_l = 1; prev_r = 0; prev_t = 1; prev_b = 0;
          @(posedge vga_clk); #1;
          return;
        end
      end
      if (done) begin
        seen_done = 1;
        check("done cycle", c, exp_addr.size() + 1);
        req = 1'b0;
      end
      @(posedge vga_clk); #1;
    end
    check("done seen", seen_done, 1);
    check("write count", n, exp_addr.size());
    check("busy after done", busy, 0);
    check("done one-cycle", done, 0);
    check("wr_en idle", wr_en, 0);
    if (hold) check("acks while busy", acks, 0);
  endtask

  initial begin
    int n, first, last_a;
    vecs[0] = '{10, 12, 20, 21, 5, 6, 12810, 13452};
    vecs[1] = '{638, 700, 479, 600, 2, 2, 307198, 307199};
    vecs[2] = '{50, 40, 0, 0, 4, 0, -1, -1};
    vecs[3] = '{0, 0, 0, 0, 7, 1, 0, 0};
    vecs[4] = '{0, 639, 470, 479, 1, 6400, 300800, 307199};
    vecs[5] = '{5, 5, 500, 600, 6, 0, -1, -1};
    repeat (2) @(posedge vga_clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset wr_en", wr_en, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_data", wr_data, 0);
    reset_n = 1'b1;
    @(posedge vga_clk); #1;
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].l, vecs[i].r, vecs[i].t, vecs[i].b, vecs[i].code, 0, -1, n, first, last_a);
      check($sformatf("vec%0d new writes", i), n - prev_n, vecs[i].n);
      if (vecs[i].n > 0) begin
        check($sformatf("vec%0d first addr", i), first, vecs[i].first);
        check($sformatf("vec%0d last addr", i), last_a, vecs[i].last);
      end
    end
    run_txn(100, 102, 200, 202, 3, 1, -1, n, first, last_a);
    check("held req writes", n - prev_n, 9);
    run_txn(300, 302, 10, 12, 6, 0, 4, n, first, last_a);
    run_txn(7, 8, 9, 9, 2, 0, -1, n, first, last_a);
    check("post-reset writes", n, 2);
    check("post-reset last", last_a, 7 + 9 * 640 + 1);
    for (int k = 0; k < 30; k++) begin
      int l, t;
      l = $urandom_range(1, 660);
      t = $urandom_range(1, 490);
      run_txn(l, l + $urandom_range(0, 6) - 1, t, t + $urandom_range(0, 4) - 1,
              $urandom_range(0, 7), 0, -1, n, first, last_a);
    end
`ifdef COLL_ERASE_PREV_EN
    run_txn(10, 12, 20, 21, 5, 0, -1, n, first, last_a);
    run_txn(11, 11, 20, 20, 3, 0, -1, n, first, last_a);
    check("erase total writes", n, 7);
    check("erase new addr", first, 12811);
    check("erase last addr", last_a, 12811);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
